// File: rtl/mfp_eic_prio_core_pkg.sv
// Shared constants for the prioritised EIC core: register map, EICR bits,
// sense-mode codes and the sense-unit start-up states.
package mfp_eic_prio_core_pkg;

  localparam int MAX_CH = 128;
  localparam int IDX_W  = 7;

  localparam logic [5:0] ADDR_EICR  = 6'h00;
  localparam logic [5:0] ADDR_EIEOI = 6'h01;

  // Four-word register groups, selected by word address bits [5:2]
  localparam logic [3:0] GRP_EIMSK  = 4'h1;
  localparam logic [3:0] GRP_EIFR   = 4'h2;
  localparam logic [3:0] GRP_EIFRS  = 4'h3;
  localparam logic [3:0] GRP_EIFRC  = 4'h4;
  localparam logic [3:0] GRP_EIISR  = 4'h5;
  localparam logic [3:0] GRP_EIIPR  = 4'h6;
  localparam logic [3:0] GRP_EISMSK = 4'h8;
  localparam logic [1:0] GRP_EIPRIO = 2'h3;

  localparam int EICR_EN   = 0;
  localparam int EICR_NEST = 1;

  typedef enum logic [1:0] {
    SENSE_LOW  = 2'b00,
    SENSE_ANY  = 2'b01,
    SENSE_FALL = 2'b10,
    SENSE_RISE = 2'b11
  } sense_mode_e;

  typedef enum logic [1:0] {
    SENSE_INIT0,
    SENSE_INIT1,
    SENSE_WORK
  } sense_state_e;

endpackage

// File: rtl/mfp_eic_prio_arbiter.sv
// Combinational priority arbiter: picks the highest-priority eligible channel,
// lowest index on ties, through a balanced log2 compare tree.
module mfp_eic_prio_arbiter
  import mfp_eic_prio_core_pkg::*;
#(
  parameter int CHANNELS  = 64,
  parameter int PRIO_BITS = 2
) (
  input  logic [CHANNELS-1:0]           eligible,
  input  logic [CHANNELS*PRIO_BITS-1:0] prio,
  output logic                          detect,
  output logic [IDX_W-1:0]              index
);

  localparam int LEVELS = $clog2(CHANNELS);
  localparam int LEAVES = 1 << LEVELS;

  typedef struct packed {
    logic                 valid;
    logic [PRIO_BITS-1:0] prio;
    logic [IDX_W-1:0]     idx;
  } node_t;

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    node_t node [LEAVES >> l];
    for (genvar j = 0; j < (LEAVES >> l); j++) begin : g_node
      if (l == 0) begin : g_leaf
        if (j < CHANNELS) begin : g_real
          assign node[j] = {eligible[j], prio[j*PRIO_BITS +: PRIO_BITS], IDX_W'(j)};
        end else begin : g_pad
          assign node[j] = '0;
        end
      end else begin : g_cmp
        node_t a, b;
        assign a = g_lvl[l-1].node[2*j];
        assign b = g_lvl[l-1].node[2*j+1];
        // Left subtree holds the lower indices, so it keeps ties
        assign node[j] = (b.valid && (!a.valid || (b.prio > a.prio))) ? b : a;
      end
    end
  end

  assign detect = g_lvl[LEVELS].node[0].valid;
  assign index  = g_lvl[LEVELS].node[0].idx;

endmodule

// File: rtl/mfp_eic_prio_core.sv
// Prioritised external interrupt controller core: sense units, flag/mask/ISR
// registers, registered arbitration and ack/EOI handshake for the CPU EIC port.
module mfp_eic_prio_core
  import mfp_eic_prio_core_pkg::*;
#(
  parameter int CHANNELS       = 64,
  parameter int SENSE_CHANNELS = 8,
  parameter int PRIO_BITS      = 2,
  parameter int ADDR_WIDTH     = 6
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [CHANNELS-1:0]   signal,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           read_data,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [31:0]           write_data,
  input  logic                  write_enable,
  input  logic                  irq_ack,
  output logic [17:1]           EIC_Offset,
  output logic [3:0]            EIC_ShadowSet,
  output logic [7:0]            EIC_Interrupt,
  output logic [5:0]            EIC_Vector,
  output logic                  EIC_Present
);

  localparam int SC = (SENSE_CHANNELS > 0) ? SENSE_CHANNELS : 1;
  localparam int PB = PRIO_BITS;

  sense_state_e sense_state, sense_state_next;
  logic en, nest;
  logic [CHANNELS-1:0] eimsk, eifr, eiisr, eifr_next, eiisr_next;
  logic [CHANNELS-1:0] sensed, pending, eligible, ack_clr, eoi_clr;
  logic [CHANNELS*PB-1:0] prio;
  logic [2*SC-1:0] esmsk;
  logic [SC-1:0] hist0, hist1;
  logic sel_detect, isr_any, ack_valid, eoi_wr;
  logic [IDX_W-1:0] sel_idx, isr_idx, ack_idx;
  logic [PB-1:0] isr_max;
  logic [5:0] waddr, raddr;
  logic [3:0] wgrp, rgrp;
  logic [1:0] wword, rword;
  logic [7:0] eic_next;
  logic [MAX_CH-1:0] msk_pad, flg_pad, isr_pad, ipr_pad, smsk_pad;
  logic [4*MAX_CH-1:0] prio_pad;

  assign waddr = 6'(write_addr);
  assign raddr = 6'(read_addr);
  assign wgrp  = waddr[5:2];
  assign wword = waddr[1:0];
  assign rgrp  = raddr[5:2];
  assign rword = raddr[1:0];

  always_ff @(posedge CLK) begin
    if (RESET) sense_state <= SENSE_INIT0;
    else       sense_state <= sense_state_next;
  end

  always_comb begin
    sense_state_next = SENSE_WORK;
    case (sense_state)
      SENSE_INIT0: sense_state_next = SENSE_INIT1;
      default:     sense_state_next = SENSE_WORK;
    endcase
  end

  // hist1 is the older sample; unsensed channels are level-high
  always_comb begin
    sensed = signal;
    for (int i = 0; i < SENSE_CHANNELS; i++) begin
      if (sense_state != SENSE_WORK) sensed[i] = 1'b0;
      else begin
        case (sense_mode_e'(esmsk[2*i +: 2]))
          SENSE_LOW:  sensed[i] = ~hist1[i] & ~hist0[i];
          SENSE_ANY:  sensed[i] = hist1[i] ^ hist0[i];
          SENSE_FALL: sensed[i] = hist1[i] & ~hist0[i];
          default:    sensed[i] = ~hist1[i] & hist0[i];
        endcase
      end
    end
  end

  mfp_eic_prio_arbiter #(.CHANNELS(CHANNELS), .PRIO_BITS(PB)) u_sel_arb (
    .eligible (eligible),
    .prio     (prio),
    .detect   (sel_detect),
    .index    (sel_idx)
  );

  mfp_eic_prio_arbiter #(.CHANNELS(CHANNELS), .PRIO_BITS(PB)) u_isr_arb (
    .eligible (eiisr),
    .prio     (prio),
    .detect   (isr_any),
    .index    (isr_idx)
  );

  assign isr_max   = prio[isr_idx*PB +: PB];
  assign ack_valid = irq_ack && (EIC_Interrupt != 8'd0);
  assign ack_idx   = EIC_Interrupt[IDX_W-1:0] - IDX_W'(1);
  assign eoi_wr    = write_enable && (waddr == ADDR_EIEOI);

  always_comb begin
    pending    = eifr & ~eiisr & eimsk;
    eligible   = '0;
    ack_clr    = '0;
    eoi_clr    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      eligible[i] = pending[i] & (~isr_any | (nest & (prio[i*PB +: PB] > isr_max)));
      ack_clr[i]  = ack_valid && (ack_idx == IDX_W'(i));
      eoi_clr[i]  = eoi_wr && isr_any && (isr_idx == IDX_W'(i));
    end
    eiisr_next = (eiisr & ~eoi_clr) | ack_clr;
    eic_next   = (en && sel_detect && !ack_valid) ? 8'(sel_idx) + 8'd1 : 8'd0;
  end

  // Software flag writes override hardware events on the bits they address
  always_comb begin
    eifr_next = (eifr & ~ack_clr) | (eimsk & sensed);
    for (int i = 0; i < CHANNELS; i++) begin
      if (write_enable && (wword == 2'(i/32))) begin
        if (wgrp == GRP_EIFR)                          eifr_next[i] = write_data[i%32];
        if ((wgrp == GRP_EIFRS) && write_data[i%32])   eifr_next[i] = 1'b1;
        if ((wgrp == GRP_EIFRC) && write_data[i%32])   eifr_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      en            <= 1'b0;
      nest          <= 1'b0;
      eimsk         <= '0;
      eifr          <= '0;
      eiisr         <= '0;
      prio          <= '0;
      esmsk         <= '0;
      hist0         <= '0;
      hist1         <= '0;
      EIC_Interrupt <= 8'd0;
    end else begin
      eifr          <= eifr_next;
      eiisr         <= eiisr_next;
      EIC_Interrupt <= eic_next;
      hist0         <= signal[SC-1:0];
      hist1         <= hist0;
      if (write_enable) begin
        if (waddr == ADDR_EICR) begin
          en   <= write_data[EICR_EN];
          nest <= write_data[EICR_NEST];
        end
        for (int i = 0; i < CHANNELS; i++) begin
          if ((wgrp == GRP_EIMSK) && (wword == 2'(i/32)))
            eimsk[i] <= write_data[i%32];
          if ((waddr[5:4] == GRP_EIPRIO) && (waddr[3:0] == 4'(i/8)))
            prio[i*PB +: PB] <= write_data[(i%8)*4 +: PB];
        end
        for (int i = 0; i < SENSE_CHANNELS; i++) begin
          if ((wgrp == GRP_EISMSK) && (wword == 2'(i/16)))
            esmsk[2*i +: 2] <= write_data[(i%16)*2 +: 2];
        end
      end
    end
  end

  assign msk_pad  = MAX_CH'(eimsk);
  assign flg_pad  = MAX_CH'(eifr);
  assign isr_pad  = MAX_CH'(eiisr);
  assign ipr_pad  = MAX_CH'(signal);
  assign smsk_pad = (SENSE_CHANNELS > 0) ? MAX_CH'(esmsk) : '0;

  always_comb begin
    prio_pad = '0;
    for (int i = 0; i < CHANNELS; i++) prio_pad[4*i +: 4] = 4'(prio[i*PB +: PB]);
    read_data = 32'd0;
    case (rgrp)
      4'h0:       read_data = (raddr == ADDR_EICR) ? {30'd0, nest, en} : 32'd0;
      GRP_EIMSK:  read_data = msk_pad[32*rword +: 32];
      GRP_EIFR:   read_data = flg_pad[32*rword +: 32];
      GRP_EIISR:  read_data = isr_pad[32*rword +: 32];
      GRP_EIIPR:  read_data = ipr_pad[32*rword +: 32];
      GRP_EISMSK: read_data = smsk_pad[32*rword +: 32];
      default: begin
        if (raddr[5:4] == GRP_EIPRIO) read_data = prio_pad[32*raddr[3:0] +: 32];
      end
    endcase
  end

  assign EIC_Offset    = '0;
  assign EIC_ShadowSet = '0;
  assign EIC_Vector    = EIC_Interrupt[5:0];
  assign EIC_Present   = en;

endmodule
